// File: rtl/gf233_mult_arbiter_if.sv
// Bundle between the scalar-multiplication sequencers, the shared GF(2^233)
// multiplier and gf233_mult_arbiter. The arbiter connects through modport slave.
interface gf233_mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_lock;
  logic [NREQ*233-1:0] req_a;
  logic [NREQ*233-1:0] req_b;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [232:0]        rsp_data;
  logic [232:0]        mult_a;
  logic [232:0]        mult_b;
  logic [232:0]        mult_c;
  logic                idle;

  modport slave (
    input  req, req_lock, req_a, req_b, mult_c,
    output gnt, rsp_valid, rsp_data, mult_a, mult_b, idle
  );

  modport master (
    output req, req_lock, req_a, req_b, mult_c,
    input  gnt, rsp_valid, rsp_data, mult_a, mult_b, idle
  );
endinterface

// File: rtl/gf233_mult_arbiter.sv
// Round-robin sharing of one pipelined GF(2^233) multiplier among NREQ requesters.
// Define GF233_ARB_LOCK_EN to let a granted requester holding req_lock keep top priority.
module gf233_mult_arbiter #(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  gf233_mult_arbiter_if.slave bus
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [232:0]         mult_a_q, mult_a_d;
  logic [232:0]         mult_b_q, mult_b_d;
  tag_t                 issue_q, issue_d;
  tag_t [MULT_LAT-1:0]  line_q, line_d;

  logic [NREQ-1:0]      gnt;
  logic                 gnt_any;
  logic [IDW-1:0]       gnt_id;
  logic                 busy;
  tag_t                 tail;

  // Grant: first asserted req scanning from ptr with wrap; operands play no part.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_any && bus.req[idx]) begin
        gnt_any  = 1'b1;
        gnt_id   = IDW'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    issue_d  = '0;
    if (gnt_any) begin
      mult_a_d = bus.req_a[int'(gnt_id)*233 +: 233];
      mult_b_d = bus.req_b[int'(gnt_id)*233 +: 233];
      issue_d  = '{valid: 1'b1, id: gnt_id};
      ptr_d    = (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
`ifdef GF233_ARB_LOCK_EN
      if (bus.req_lock[gnt_id]) ptr_d = gnt_id;
`endif
    end
  end

`ifndef GF233_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  // The issue tag sits beside mult_a/mult_b, so the MULT_LAT-deep line behind it
  // presents each tag at its tail in the same cycle the product appears on mult_c.
  always_comb begin
    line_d[0] = issue_q;
    for (int unsigned k = 1; k < MULT_LAT; k++) begin
      line_d[k] = line_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      issue_q  <= '0;
      line_q   <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      issue_q  <= issue_d;
      line_q   <= line_d;
    end
  end

  always_comb begin
    busy = issue_q.valid;
    for (int unsigned k = 0; k < MULT_LAT; k++) begin
      busy = busy | line_q[k].valid;
    end
  end

  assign tail = line_q[MULT_LAT-1];

  always_comb begin
    bus.rsp_valid = '0;
    if (tail.valid) bus.rsp_valid[tail.id] = 1'b1;
  end

  assign bus.rsp_data = tail.valid ? bus.mult_c : '0;
  assign bus.gnt      = gnt;
  assign bus.mult_a   = mult_a_q;
  assign bus.mult_b   = mult_b_q;
  assign bus.idle     = ~(|bus.req) & ~busy;

endmodule
